// File: rtl/pwm_ctrl_pkg.sv
// Shared types and derived constants for the PWM arm/commit front-end.
// Imported by the sequencer top and the per-channel slew limiter.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_e;

    // Minimum of 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int duty_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int tick_div(input int sys_clk, input int hz);
        return sys_clk / hz;
    endfunction

endpackage

// File: rtl/pwm_arm_sequencer_slew.sv
// One channel: committed target plus the slew-limited duty register.
// Force-idle wins over stepping; target-idle wins over loading.
module pwm_slew_limiter
    import pwm_ctrl_pkg::*;
#(
    parameter int BIT_RES   = 8,
    parameter int SLEW      = 4,
    parameter int IDLE_DUTY = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [BIT_RES-1:0] i_shadow,
    input  logic               i_tgt_idle,
    input  logic               i_step,
    input  logic               i_force_idle,
    output logic [BIT_RES-1:0] o_duty
);

    localparam logic [BIT_RES-1:0] IDLE = BIT_RES'(IDLE_DUTY);
    localparam logic signed [BIT_RES:0] STEP = (BIT_RES+1)'(SLEW);

    logic [BIT_RES-1:0]        r_target;
    logic [BIT_RES-1:0]        r_duty;
    logic [BIT_RES-1:0]        w_next;
    logic signed [BIT_RES:0]   w_diff;

    // Extra sign bit keeps the distance exact in both directions.
    assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_duty});

    always_comb begin
        w_next = r_target;
        if (w_diff > STEP) begin
            w_next = r_duty + BIT_RES'(SLEW);
        end else if (w_diff < -STEP) begin
            w_next = r_duty - BIT_RES'(SLEW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= IDLE;
            r_duty   <= IDLE;
        end else begin
            if (i_tgt_idle) begin
                r_target <= IDLE;
            end else if (i_load) begin
                r_target <= i_shadow;
            end
            if (i_force_idle) begin
                r_duty <= IDLE;
            end else if (i_step) begin
                r_duty <= w_next;
            end
        end
    end

    assign o_duty = r_duty;

endmodule

// File: rtl/pwm_arm_sequencer.sv
// Host duty frames -> shadow -> tick-aligned commit -> slew-limited PWM duty.
// Owns the arming, watchdog and failsafe sequencing.
module pwm_arm_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int SYS_CLK    = 100000000,
    parameter int UPDATE_HZ  = 1000,
    parameter int CHANNELS   = 4,
    parameter int BIT_RES    = 8,
    parameter int SLEW       = 4,
    parameter int ARM_TICKS  = 50,
    parameter int WDOG_TICKS = 100,
    parameter int IDLE_DUTY  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm_req,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [clog2(CHANNELS)-1:0]  wr_ch,
    input  logic [BIT_RES-1:0]          wr_duty,
    input  logic                        wr_last,
    output logic [CHANNELS*BIT_RES-1:0] duty_out,
    output logic                        pwm_ena,
    output logic [1:0]                  state,
    output logic                        failsafe,
    output logic                        tick
);

    localparam int TDIV = tick_div(SYS_CLK, UPDATE_HZ);
    localparam int TW   = clog2(TDIV);
    localparam int AW   = clog2(ARM_TICKS + 1);
    localparam int WW   = clog2(WDOG_TICKS + 1);
    localparam logic [BIT_RES-1:0] DMAX = BIT_RES'(duty_max(BIT_RES));
    localparam logic [BIT_RES-1:0] IDLE = BIT_RES'(IDLE_DUTY);

    state_e             r_state;
    state_e             w_nxt;
    logic [TW-1:0]      r_tick_cnt;
    logic [AW-1:0]      r_arm_cnt;
    logic [WW-1:0]      r_wdog;
    logic               r_pending;
    logic               r_wr_ready;
    logic               r_pwm_ena;
    logic               r_failsafe;
    logic [BIT_RES-1:0] r_shadow [CHANNELS];
    logic [BIT_RES-1:0] w_duty   [CHANNELS];
    logic [BIT_RES-1:0] w_clamped;
    logic               w_tick;
    logic               w_acc;
    logic               w_commit;
    logic               w_disarm;
    logic               w_all_idle;
    logic               w_slew_en;
    logic               w_tgt_idle;

    assign w_tick     = (r_tick_cnt == TW'(TDIV - 1));
    assign w_acc      = wr_valid & r_wr_ready;
    assign w_commit   = w_tick & r_pending & (r_state == ST_ARMED);
    assign w_disarm   = (w_nxt == ST_DISARMED);
    assign w_slew_en  = w_tick & ((r_state == ST_ARMED) | (r_state == ST_FAILSAFE));
    assign w_tgt_idle = w_disarm | (r_state == ST_FAILSAFE);
    assign w_clamped  = (wr_duty > DMAX) ? DMAX : wr_duty;

    always_comb begin
        w_all_idle = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_duty[k] != IDLE) w_all_idle = 1'b0;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_DISARMED: if (arm_req) w_nxt = ST_ARMING;
            ST_ARMING: begin
                if (!arm_req) w_nxt = ST_DISARMED;
                else if (w_tick && r_arm_cnt == AW'(ARM_TICKS - 1)) w_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!arm_req) w_nxt = ST_DISARMED;
                else if (w_tick && !w_commit && r_wdog == WW'(WDOG_TICKS - 1))
                    w_nxt = ST_FAILSAFE;
            end
            ST_FAILSAFE: if (!arm_req && w_all_idle) w_nxt = ST_DISARMED;
            default: w_nxt = ST_DISARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_DISARMED;
            r_tick_cnt <= '0;
            r_arm_cnt  <= '0;
            r_wdog     <= '0;
            r_pending  <= 1'b0;
            r_wr_ready <= 1'b0;
            r_pwm_ena  <= 1'b0;
            r_failsafe <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) r_shadow[k] <= IDLE;
        end else begin
            r_state    <= w_nxt;
            r_wr_ready <= (w_nxt == ST_ARMING) || (w_nxt == ST_ARMED);
            r_pwm_ena  <= (w_nxt != ST_DISARMED);
            r_failsafe <= (w_nxt == ST_FAILSAFE);
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

            if (r_state != ST_ARMING) r_arm_cnt <= '0;
            else if (w_tick) r_arm_cnt <= r_arm_cnt + 1'b1;

            if (r_state != ST_ARMED || w_commit) r_wdog <= '0;
            else if (w_tick) r_wdog <= r_wdog + 1'b1;

            // A last beat landing on the commit tick re-arms the next commit.
            if (w_disarm) r_pending <= 1'b0;
            else if (w_acc && wr_last) r_pending <= 1'b1;
            else if (w_commit) r_pending <= 1'b0;

            for (int k = 0; k < CHANNELS; k++) begin
                if (w_disarm) r_shadow[k] <= IDLE;
                else if (w_acc && int'(wr_ch) == k) r_shadow[k] <= w_clamped;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pwm_slew_limiter #(
            .BIT_RES   (BIT_RES),
            .SLEW      (SLEW),
            .IDLE_DUTY (IDLE_DUTY)
        ) u_slew (
            .clk          (clk),
            .rst          (rst),
            .i_load       (w_commit),
            .i_shadow     (r_shadow[k]),
            .i_tgt_idle   (w_tgt_idle),
            .i_step       (w_slew_en),
            .i_force_idle (w_disarm),
            .o_duty       (w_duty[k])
        );
        assign duty_out[k*BIT_RES +: BIT_RES] = w_duty[k];
    end

    assign wr_ready = r_wr_ready;
    assign pwm_ena  = r_pwm_ena;
    assign failsafe = r_failsafe;
    assign state    = r_state;
    assign tick     = w_tick;

endmodule
